// File: rtl/rom_loader_if.sv
// Download/SDRAM-write bus between hps_io, rom_loader and the SDRAM write port.
// master: download source and SDRAM acknowledge side; slave: the loader.
interface rom_loader_if #(
  parameter int ADDR_W = 22
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] sd_waddr;
  logic [7:0]        sd_din;
  logic              sd_we;
  logic              sd_we_ack;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
    input  ioctl_wait, sd_waddr, sd_din, sd_we
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
    output ioctl_wait, sd_waddr, sd_din, sd_we
  );
endinterface

// File: rtl/rom_loader.sv
// ROM loader: turns the ioctl byte stream into toggle-handshake SDRAM writes,
// stalls hps_io while a write is outstanding, and at end of download reports
// copier-header presence, read base and a power-of-two cartridge address mask.
module rom_loader #(
  parameter int ADDR_W    = 22,
  parameter int HDR_BYTES = 512,
  parameter int GG_INDEX  = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  rom_loader_if.slave       bus,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [ADDR_W-1:0] rom_base,
  output logic              hdr_present,
  output logic              gg,
  output logic              load_done
);

  localparam int                HB      = $clog2(HDR_BYTES);
  localparam logic [25:0]       LEN_MAX = 26'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] HDR_VAL = ADDR_W'(HDR_BYTES);
  localparam logic [ADDR_W+1:0] ONE     = (ADDR_W+2)'(1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  state_t              state, state_nxt;
  logic                dl_prev;
  logic                tog_pend;
  logic [24:0]         addr_q;
  logic [ADDR_W:0]     len;
  logic                ack_eq;
  logic                accept;
  logic                do_toggle;
  logic                wr_done;
  logic                hdr_f;
  logic [ADDR_W-1:0]   base_f;
  logic signed [ADDR_W+1:0] eff_f;
  logic                unused_idx;

  assign ack_eq     = (bus.sd_we == bus.sd_we_ack);
  assign unused_idx = &{1'b0, bus.ioctl_index[7:5]};

  // Byte count from the last written address; saturates at the full SDRAM span.
  function automatic logic [ADDR_W:0] sat_len(input logic [24:0] a);
    logic [25:0] n;
    n = {1'b0, a} + 26'd1;
    if (n > LEN_MAX) n = LEN_MAX;
    return n[ADDR_W:0];
  endfunction

  // Smear the MSB of a positive value downwards; zero or negative gives 0.
  function automatic logic [ADDR_W-1:0] smear_mask(input logic signed [ADDR_W+1:0] e);
    logic [ADDR_W-1:0] m;
    m = '0;
    if (e > 0) begin
      m[ADDR_W-1] = e[ADDR_W-1];
      for (int i = ADDR_W - 2; i >= 0; i--) m[i] = m[i+1] | e[i];
    end
    return m;
  endfunction

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle handshake strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_toggle = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ioctl_download && !dl_prev) state_nxt = RECV;
      end
      RECV: begin
        if (!bus.ioctl_download) begin
          state_nxt = FINISH;
        end else if (bus.ioctl_wr && !bus.ioctl_wait) begin
          accept    = 1'b1;
          do_toggle = ack_eq;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // A byte accepted while the previous toggle was still unpaired is
        // toggled here once the acknowledge catches up.
        if (tog_pend) begin
          do_toggle = ack_eq;
        end else if (ack_eq) begin
          wr_done   = 1'b1;
          state_nxt = RECV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall, pending-toggle and done-pulse control; download level history.
  always_ff @(posedge clk_sys) begin
    dl_prev <= bus.ioctl_download;
    if (reset) begin
      bus.ioctl_wait <= 1'b0;
      tog_pend       <= 1'b0;
      load_done      <= 1'b0;
    end else begin
      load_done <= (state == FINISH);
      if (accept)         bus.ioctl_wait <= 1'b1;
      else if (wr_done)   bus.ioctl_wait <= 1'b0;
      if (accept)         tog_pend <= !ack_eq;
      else if (do_toggle) tog_pend <= 1'b0;
    end
  end

  // Write request toggle; never reset so an in-flight request stays paired.
  always_ff @(posedge clk_sys) begin
    if (do_toggle) bus.sd_we <= ~bus.sd_we;
  end

  // Captured address and running byte count, cleared while idle.
  always_ff @(posedge clk_sys) begin
    if (state == IDLE) begin
      addr_q <= '0;
      len    <= '0;
    end else begin
      if (accept)  addr_q <= bus.ioctl_addr;
      if (wr_done) len    <= sat_len(addr_q);
    end
  end

  // Cartridge geometry derived from the final byte count.
  always_comb begin
    hdr_f  = len[HB] && (len[HB-1:0] == '0);
    base_f = hdr_f ? HDR_VAL : '0;
    eff_f  = $signed({1'b0, len}) - $signed({2'b00, base_f}) - $signed(ONE);
  end

  // Write data/address latch, media type, and geometry outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.sd_waddr <= '0;
      bus.sd_din   <= '0;
      gg           <= 1'b0;
      cart_mask    <= '0;
      rom_base     <= '0;
      hdr_present  <= 1'b0;
    end else begin
      if (accept) begin
        bus.sd_waddr <= bus.ioctl_addr[ADDR_W-1:0];
        bus.sd_din   <= bus.ioctl_dout;
        if (bus.ioctl_addr == '0) gg <= (bus.ioctl_index[4:0] == 5'(GG_INDEX));
      end
      if (state == FINISH) begin
        hdr_present <= hdr_f;
        rom_base    <= base_f;
        cart_mask   <= smear_mask(eff_f);
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: table of whole-image downloads plus hand-written
// sequences for ack hold-off, address saturation and reset mid-write.
module tb_rom_loader;

  localparam int LOGN = 16384;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [21:0]       cart_mask;
  logic [21:0]       rom_base;
  logic              hdr_present;
  logic              gg;
  logic              load_done;

  rom_loader_if #(.ADDR_W(22)) bus ();

  rom_loader #(.ADDR_W(22), .HDR_BYTES(512), .GG_INDEX(2)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus.slave),
    .cart_mask   (cart_mask),
    .rom_base    (rom_base),
    .hdr_present (hdr_present),
    .gg          (gg),
    .load_done   (load_done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  int to_cnt  = 0;

  // SDRAM acknowledge model
  int ack_delay  = 0;
  int hold_addr  = -1;
  bit ack_freeze = 1'b1;
  int rcnt       = 0;
  always @(posedge clk_sys) begin
    if (!ack_freeze) begin
      if (bus.sd_we != bus.sd_we_ack) begin
        if (rcnt >= ((32'(bus.sd_waddr) == hold_addr) ? 50 : ack_delay)) begin
          bus.sd_we_ack <= bus.sd_we;
          rcnt <= 0;
        end else begin
          rcnt <= rcnt + 1;
        end
      end else begin
        rcnt <= 0;
      end
    end
  end

  // Write-toggle and done-pulse monitor
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  bit          mon_init = 1'b0;
  logic        we_prev;
  logic [21:0] log_addr [LOGN];
  logic [7:0]  log_din  [LOGN];
  int          log_cyc  [LOGN];
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) begin
    if (mon_init && bus.sd_we != we_prev) begin
      if (wr_cnt < LOGN) begin
        log_addr[wr_cnt] = bus.sd_waddr;
        log_din[wr_cnt]  = bus.sd_din;
        log_cyc[wr_cnt]  = cyc;
      end
      wr_cnt++;
    end
    we_prev  = bus.sd_we;
    mon_init = 1'b1;
    if (load_done) done_cnt++;
  end

  typedef struct {
    int          nbytes;
    logic [7:0]  idx;
    int          delay;
    logic        hdr;
    logic [21:0] base;
    logic [21:0] mask;
    logic        gg;
  } vec_t;

  vec_t vecs [7];
  int   stall_at [16];

  function automatic logic [7:0] pat(input int a);
    logic [31:0] v;
    v = 32'(a);
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
  endtask

  // Wait for ioctl_wait to drop; optionally inject an illegal strobe mid-stall.
  task automatic wait_ready(input bit inject, output int stall);
    stall = 0;
    while (bus.ioctl_wait && stall < 400) begin
      if (inject && stall == 10) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'd99;
        bus.ioctl_dout = 8'hFF;
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      @(negedge clk_sys);
      stall++;
    end
    bus.ioctl_wr = 1'b0;
    if (stall >= 400) to_cnt++;
  endtask

  // Whole image; download drops right after the last strobe, write still pending.
  task automatic send_image(input int n, input logic [7:0] idx, input int inject_at);
    int s;
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int a = 0; a < n; a++) begin
      wait_ready(a == inject_at, s);
      if (a < 16) stall_at[a] = s;
      send_byte(25'(a), pat(a));
    end
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    repeat (5) @(negedge clk_sys);
    check({name, "_load_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_order(input string name, input int base, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++)
      if (log_addr[base+i] != 22'(i) || log_din[base+i] != pat(i)) errs++;
    check({name, "_order"}, 32'(errs), 32'd0);
    check({name, "_writes"}, 32'(wr_cnt - base), 32'(n));
  endtask

  initial begin
    int base, d0, gap;

    vecs[0] = '{nbytes: 4096, idx: 8'd1,    delay: 3, hdr: 1'b0, base: 22'h000, mask: 22'h000FFF, gg: 1'b0};
    vecs[1] = '{nbytes: 4608, idx: 8'd2,    delay: 0, hdr: 1'b1, base: 22'h200, mask: 22'h000FFF, gg: 1'b1};
    vecs[2] = '{nbytes: 3072, idx: 8'd1,    delay: 0, hdr: 1'b0, base: 22'h000, mask: 22'h000FFF, gg: 1'b0};
    vecs[3] = '{nbytes: 0,    idx: 8'd2,    delay: 0, hdr: 1'b0, base: 22'h000, mask: 22'h000000, gg: 1'b0};
    vecs[4] = '{nbytes: 1,    idx: 8'h22,   delay: 1, hdr: 1'b0, base: 22'h000, mask: 22'h000000, gg: 1'b1};
    vecs[5] = '{nbytes: 512,  idx: 8'd1,    delay: 0, hdr: 1'b1, base: 22'h200, mask: 22'h000000, gg: 1'b0};
    vecs[6] = '{nbytes: 513,  idx: 8'd1,    delay: 2, hdr: 1'b0, base: 22'h000, mask: 22'h0003FF, gg: 1'b0};

    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    ack_freeze = 1'b0;
    check("rst_ioctl_wait",  32'(bus.ioctl_wait), 32'd0);
    check("rst_load_done",   32'(load_done), 32'd0);
    check("rst_sd_waddr",    32'(bus.sd_waddr), 32'd0);
    check("rst_sd_din",      32'(bus.sd_din), 32'd0);
    check("rst_cart_mask",   32'(cart_mask), 32'd0);
    check("rst_rom_base",    32'(rom_base), 32'd0);
    check("rst_hdr_present", 32'(hdr_present), 32'd0);
    check("rst_gg",          32'(gg), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);

    for (int v = 0; v < 7; v++) begin
      ack_delay = vecs[v].delay;
      base = wr_cnt;
      d0   = done_cnt;
      send_image(vecs[v].nbytes, vecs[v].idx, -1);
      wait_done($sformatf("v%0d", v), d0);
      check_order($sformatf("v%0d", v), base, vecs[v].nbytes);
      check($sformatf("v%0d_hdr_present", v), 32'(hdr_present), 32'(vecs[v].hdr));
      check($sformatf("v%0d_rom_base", v),    32'(rom_base),    32'(vecs[v].base));
      check($sformatf("v%0d_cart_mask", v),   32'(cart_mask),   32'(vecs[v].mask));
      check($sformatf("v%0d_gg", v),          32'(gg),          32'(vecs[v].gg));
      check($sformatf("v%0d_wait_idle", v),   32'(bus.ioctl_wait), 32'd0);
      repeat (4) @(negedge clk_sys);
    end

    // Ack held off on byte 5, with an illegal strobe during the stall
    ack_delay = 0;
    hold_addr = 5;
    base = wr_cnt;
    d0   = done_cnt;
    send_image(8, 8'd1, 6);
    wait_done("hold", d0);
    hold_addr = -1;
    check_order("hold", base, 8);
    check("hold_stall_cycles", 32'(stall_at[6] >= 50), 32'd1);
    gap = log_cyc[base+6] - log_cyc[base+5];
    check("hold_byte6_not_early", 32'(gap >= 50), 32'd1);
    check("hold_addr5_data", 32'(log_din[base+5]), 32'(pat(5)));
    check("hold_cart_mask", 32'(cart_mask), 32'h7);
    repeat (4) @(negedge clk_sys);

    // Address beyond the SDRAM span: wraps for the write, length saturates
    base = wr_cnt;
    d0   = done_cnt;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(25'h400005, 8'h3C);
    bus.ioctl_download = 1'b0;
    wait_done("sat", d0);
    check("sat_writes", 32'(wr_cnt - base), 32'd1);
    check("sat_waddr", 32'(log_addr[base]), 32'd5);
    check("sat_din", 32'(log_din[base]), 32'h3C);
    check("sat_cart_mask", 32'(cart_mask), 32'h3FFFFF);
    check("sat_hdr_present", 32'(hdr_present), 32'd0);
    repeat (4) @(negedge clk_sys);

    // Reset while a toggle is outstanding
    ack_freeze = 1'b1;
    base = wr_cnt;
    bus.ioctl_index    = 8'd2;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(25'd0, 8'h11);
    @(negedge clk_sys);
    check("rstw_wait_before", 32'(bus.ioctl_wait), 32'd1);
    check("rstw_gg_before", 32'(gg), 32'd1);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("rstw_wait_after", 32'(bus.ioctl_wait), 32'd0);
    check("rstw_mask_after", 32'(cart_mask), 32'd0);
    check("rstw_gg_after", 32'(gg), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rstw_one_toggle", 32'(wr_cnt - base), 32'd1);
    d0 = done_cnt;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(25'd0, 8'hA5);
    repeat (10) @(negedge clk_sys);
    check("rstw_no_early_toggle", 32'(wr_cnt - base), 32'd1);
    check("rstw_stalled", 32'(bus.ioctl_wait), 32'd1);
    ack_freeze = 1'b0;
    begin
      int s;
      wait_ready(1'b0, s);
    end
    bus.ioctl_download = 1'b0;
    wait_done("rstw", d0);
    check("rstw_toggles", 32'(wr_cnt - base), 32'd2);
    check("rstw_waddr", 32'(log_addr[base+1]), 32'd0);
    check("rstw_din", 32'(log_din[base+1]), 32'hA5);
    check("rstw_cart_mask", 32'(cart_mask), 32'd0);
    check("rstw_gg", 32'(gg), 32'd0);

    check("stall_timeouts", 32'(to_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
